// File: rtl/lpad_commit_ctrl_pkg.sv
// Landing-pad (Zicfilp) commit control: shared types and constants.
//
// Holds the minimal slice of core types the landing-pad sequencer needs:
// core config, ELP/LPL state types, exception and scoreboard entry layout,
// the software-check cause/tval, and a helper telling whether an op writes rd.
package lpad_commit_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    int unsigned NrCommitPorts;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

  typedef enum logic {
    NO_LPAD_EXPECTED = 1'b0,
    LPAD_EXPECTED    = 1'b1
  } elp_t;

  localparam int unsigned LPAD_LABEL_BITS = 20;
  typedef logic [LPAD_LABEL_BITS-1:0] lpl_t;

  // Software-check exception, landing-pad fault code.
  localparam logic [XLEN-1:0] LPAD_EXCEPTION_CAUSE = 32'd18;
  localparam logic [XLEN-1:0] LPAD_EXCEPTION_TVAL  = 32'd2;

  typedef enum logic [3:0] {
    ADD,
    ADDI,
    LOAD,
    STORE,
    BRANCH,
    JALR,
    ZICFI_LPAD
  } fu_op_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  // For ZICFI_LPAD entries the landing-pad label travels in the result field.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    fu_op_t          op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    logic            valid;
    exception_t      ex;
  } scoreboard_entry_t;

  function automatic logic writes_rd(fu_op_t op);
    return !(op inside {STORE, BRANCH});
  endfunction

endpackage

// File: rtl/lpad_commit_ctrl_check_slice.sv
// Combinational landing-pad check for a single commit port.
//
// Ports:
//   lpe_i    enforcement enable
//   elp_i    ELP as left by earlier (acked) ports      elp_o   ELP after this port
//   lpl_i    label as left by earlier ports            lpl_o   label after this port
//   stop_i   an earlier port ended the scan            stop_o  scan ends at/after this port
//   entry_i  scoreboard entry offered on this port     entry_o entry with CFI exception injected
//   ack_i    this port commits                         viol_o  this port raised a violation
module lpad_check_slice
  import lpad_commit_ctrl_pkg::*;
(
  input  logic              lpe_i,
  input  elp_t              elp_i,
  input  lpl_t              lpl_i,
  input  logic              stop_i,
  input  scoreboard_entry_t entry_i,
  input  logic              ack_i,
  output elp_t              elp_o,
  output lpl_t              lpl_o,
  output logic              stop_o,
  output scoreboard_entry_t entry_o,
  output logic              viol_o
);

  logic live;
  logic check;
  logic label_bad;
  logic viol;

  always_comb begin
    // live: the port takes part in the scan; check: it is also subject to enforcement.
    live      = !stop_i && entry_i.valid && !entry_i.ex.valid;
    check     = live && lpe_i;
    // Label 0 is the wildcard landing pad.
    label_bad = (entry_i.result != '0) &&
                (entry_i.result[LPAD_LABEL_BITS-1:0] != lpl_i);
    viol      = check && (elp_i == LPAD_EXPECTED) &&
                ((entry_i.op != ZICFI_LPAD) || (entry_i.pc[1:0] != 2'b00) || label_bad);

    elp_o   = elp_i;
    lpl_o   = lpl_i;
    entry_o = entry_i;
    stop_o  = !live || viol;
    viol_o  = viol;

    if (viol) begin
      entry_o.ex.valid = 1'b1;
      entry_o.ex.cause = LPAD_EXCEPTION_CAUSE;
      entry_o.ex.tval  = LPAD_EXCEPTION_TVAL;
    end

    if (check && (elp_i == LPAD_EXPECTED)) begin
      if (ack_i) begin
        elp_o = NO_LPAD_EXPECTED;
      end
    end else if (live && ack_i) begin
      // Returns (x1/x5) and the x7 software-guarded jump do not need a landing pad.
      if (check && (entry_i.op == JALR) && !(entry_i.rs1 inside {5'd1, 5'd5, 5'd7})) begin
        elp_o = LPAD_EXPECTED;
      end else if (writes_rd(entry_i.op) && (entry_i.rd == 5'd7)) begin
        lpl_o = entry_i.result[LPAD_LABEL_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/lpad_commit_ctrl.sv
// Landing-pad (Zicfilp) commit sequencer.
//
// Scans the commit ports in order, injects software-check exceptions on CFI
// violations and owns the ELP/LPL state plus the trap-saved PELP.
// Optional feature: define LPAD_VIOL_CNT_EN to add a saturating violation counter.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   lpe_i            enforcement enable for the current privilege
//   flush_i          pipeline flush, nothing commits and state holds
//   trap_i, eret_i   trap taken / xRET retiring this cycle (trap wins)
//   commit_instr_i   entries offered for commit, commit_ack_i per-port ack
//   commit_instr_o   entries with CFI exception injected
//   elp_o, lpl_o     current expected-landing-pad state and label
//   pelp_o           ELP saved at the last trap
//   viol_o           registered pulse, an acked port violated last cycle
//   viol_cnt_o       saturating violation count (zero without the counter)
module lpad_commit_ctrl
  import lpad_commit_ctrl_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg  = cva6_cfg_empty,
  parameter int unsigned NrPorts  = CVA6Cfg.NrCommitPorts,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lpe_i,
  input  logic                flush_i,
  input  logic                trap_i,
  input  logic                eret_i,
  input  scoreboard_entry_t   commit_instr_i [NrPorts],
  input  logic [NrPorts-1:0]  commit_ack_i,
  output scoreboard_entry_t   commit_instr_o [NrPorts],
  output elp_t                elp_o,
  output lpl_t                lpl_o,
  output elp_t                pelp_o,
  output logic                viol_o,
  output logic [CntWidth-1:0] viol_cnt_o
);

  elp_t elp_q, elp_d;
  elp_t pelp_q, pelp_d;
  lpl_t lpl_q, lpl_d;
  logic viol_q, viol_d;

  elp_t              elp_chain  [NrPorts+1];
  lpl_t              lpl_chain  [NrPorts+1];
  logic              stop_chain [NrPorts+1];
  scoreboard_entry_t scan_entry [NrPorts];
  logic              viol_raw   [NrPorts];

  assign elp_chain[0]  = elp_q;
  assign lpl_chain[0]  = lpl_q;
  assign stop_chain[0] = 1'b0;

  for (genvar i = 0; i < NrPorts; i++) begin : g_slice
    lpad_check_slice u_slice (
      .lpe_i   (lpe_i),
      .elp_i   (elp_chain[i]),
      .lpl_i   (lpl_chain[i]),
      .stop_i  (stop_chain[i]),
      .entry_i (commit_instr_i[i]),
      .ack_i   (commit_ack_i[i]),
      .elp_o   (elp_chain[i+1]),
      .lpl_o   (lpl_chain[i+1]),
      .stop_o  (stop_chain[i+1]),
      .entry_o (scan_entry[i]),
      .viol_o  (viol_raw[i])
    );
  end

  logic unused_stop;
  assign unused_stop = stop_chain[NrPorts];

  // ELP to save on a trap: the value seen by the first excepting port, or NO if
  // that port is itself a landing-pad violation. Without an excepting port (e.g.
  // interrupt) the ELP after all committed ports is saved.
  elp_t trap_elp;
  logic trap_found;

  always_comb begin
    trap_elp   = elp_chain[NrPorts];
    trap_found = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      if (!trap_found && scan_entry[i].valid && scan_entry[i].ex.valid) begin
        trap_found = 1'b1;
        trap_elp   = viol_raw[i] ? NO_LPAD_EXPECTED : elp_chain[i];
      end
    end
  end

  always_comb begin
    viol_d = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      commit_instr_o[i] = flush_i ? commit_instr_i[i] : scan_entry[i];
      if (!flush_i && viol_raw[i] && commit_ack_i[i]) begin
        viol_d = 1'b1;
      end
    end
  end

  always_comb begin
    elp_d  = elp_q;
    pelp_d = pelp_q;
    lpl_d  = lpl_q;
    if (!flush_i) begin
      // Acked x7 writes commit regardless of trap/xRET/enforcement.
      lpl_d = lpl_chain[NrPorts];
      if (trap_i) begin
        pelp_d = trap_elp;
        elp_d  = NO_LPAD_EXPECTED;
      end else if (eret_i) begin
        elp_d  = pelp_q;
        pelp_d = NO_LPAD_EXPECTED;
      end else if (!lpe_i) begin
        elp_d  = NO_LPAD_EXPECTED;
      end else begin
        elp_d  = elp_chain[NrPorts];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elp_q  <= NO_LPAD_EXPECTED;
      pelp_q <= NO_LPAD_EXPECTED;
      lpl_q  <= '0;
      viol_q <= 1'b0;
    end else begin
      elp_q  <= elp_d;
      pelp_q <= pelp_d;
      lpl_q  <= lpl_d;
      viol_q <= viol_d;
    end
  end

`ifdef LPAD_VIOL_CNT_EN
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Counts alongside viol_q so the count already includes the pulse on viol_o.
  assign cnt_d = (viol_d && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign viol_cnt_o = cnt_q;
`else
  assign viol_cnt_o = '0;
`endif

  assign elp_o  = elp_q;
  assign lpl_o  = lpl_q;
  assign pelp_o = pelp_q;
  assign viol_o = viol_q;

endmodule

// File: tb/tb_lpad_commit_ctrl.sv
module tb_lpad_commit_ctrl;
  import lpad_commit_ctrl_pkg::*;

  localparam int NP = 2;
  localparam int CW = 2;
`ifdef LPAD_VIOL_CNT_EN
  localparam int CNT_MAX = (1 << CW) - 1;
`else
  localparam int CNT_MAX = 0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic lpe, flush, trap, eret;
  scoreboard_entry_t cin [NP];
  scoreboard_entry_t cout [NP];
  logic [NP-1:0] ack;
  elp_t elp_o, pelp_o;
  lpl_t lpl_o;
  logic viol_o;
  logic [CW-1:0] viol_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lpad_commit_ctrl #(
    .NrPorts  (NP),
    .CntWidth (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .lpe_i          (lpe),
    .flush_i        (flush),
    .trap_i         (trap),
    .eret_i         (eret),
    .commit_instr_i (cin),
    .commit_ack_i   (ack),
    .commit_instr_o (cout),
    .elp_o          (elp_o),
    .lpl_o          (lpl_o),
    .pelp_o         (pelp_o),
    .viol_o         (viol_o),
    .viol_cnt_o     (viol_cnt_o)
  );

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit        m_elp, m_pelp, m_viol;
  bit [19:0] m_lpl;
  int        m_cnt;
  bit        n_elp, n_pelp, n_viol;
  bit [19:0] n_lpl;
  int        n_cnt;
  bit        m_ok = 1'b0;
  scoreboard_entry_t exp_out [NP];

  task automatic model_eval();
    bit e, halted, tfound, telp, anyv, v, ok;
    bit [19:0] l;
    e = m_elp; l = m_lpl; halted = 0; tfound = 0; telp = 0; anyv = 0;
    for (int p = 0; p < NP; p++) begin
      exp_out[p] = cin[p];
      v = 0;
      if (!flush) begin
        if (!halted && cin[p].valid && !cin[p].ex.valid) begin
          if (lpe && e) begin
            ok = (cin[p].op == ZICFI_LPAD) && (cin[p].pc[1:0] == 0) &&
                 ((cin[p].result == 0) || (cin[p].result[19:0] == l));
            if (!ok) begin
              v = 1; halted = 1;
              exp_out[p].ex = '{cause: 32'd18, tval: 32'd2, valid: 1'b1};
              if (ack[p]) anyv = 1;
            end
          end
          if (!tfound && exp_out[p].ex.valid) begin tfound = 1; telp = v ? 0 : e; end
          if (ack[p]) begin
            if (lpe && e) e = 0;
            else if (lpe && cin[p].op == JALR && !(cin[p].rs1 inside {1, 5, 7})) e = 1;
            else if (cin[p].rd == 7 && cin[p].op != STORE && cin[p].op != BRANCH)
              l = cin[p].result[19:0];
          end
        end else begin
          halted = 1;
          if (!tfound && cin[p].valid && cin[p].ex.valid) begin tfound = 1; telp = e; end
        end
      end
    end
    n_elp = m_elp; n_pelp = m_pelp; n_lpl = m_lpl; n_viol = anyv; n_cnt = m_cnt;
    if (!flush) begin
      n_lpl = l;
      if (trap) begin n_pelp = tfound ? telp : e; n_elp = 0; end
      else if (eret) begin n_elp = m_pelp; n_pelp = 0; end
      else if (!lpe) n_elp = 0;
      else n_elp = e;
    end
    if (n_viol && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
  endtask

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_ok = 1'b0;
    end else begin
      model_eval();
      for (int p = 0; p < NP; p++) chk($sformatf("model port%0d entry", p), cout[p], exp_out[p]);
      chk("model elp", elp_o, m_elp);
      chk("model lpl", lpl_o, m_lpl);
      chk("model pelp", pelp_o, m_pelp);
      chk("model viol", viol_o, m_viol);
      chk("model viol_cnt", viol_cnt_o, m_cnt);
      m_ok = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_elp <= 0; m_pelp <= 0; m_lpl <= '0; m_viol <= 0; m_cnt <= 0;
    end else if (m_ok) begin
      m_elp <= n_elp; m_pelp <= n_pelp; m_lpl <= n_lpl; m_viol <= n_viol; m_cnt <= n_cnt;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic scoreboard_entry_t mk(fu_op_t op, logic [4:0] rs1, logic [4:0] rd,
                                           logic [31:0] res, logic [31:0] pc);
    scoreboard_entry_t s;
    s = '0;
    s.op = op; s.rs1 = rs1; s.rd = rd; s.result = res; s.pc = pc; s.valid = 1'b1;
    return s;
  endfunction

  task automatic idle();
    for (int p = 0; p < NP; p++) cin[p] = '0;
    ack = '0; flush = 0; trap = 0; eret = 0; lpe = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic violate();
    cin[0] = mk(JALR, 5'd10, 5'd0, 32'h0, 32'h100); ack = 2'b01;
    step();
    cin[0] = mk(ADD, 5'd2, 5'd3, 32'h0, 32'h200); ack = 2'b01;
    step();
  endtask

  function automatic scoreboard_entry_t rnd_entry();
    scoreboard_entry_t s;
    logic [31:0] labels [4];
    logic [4:0] regs [5];
    int r;
    labels[0] = 32'h0; labels[1] = 32'h1; labels[2] = 32'h12345; labels[3] = 32'h5;
    regs[0] = 5'd1; regs[1] = 5'd5; regs[2] = 5'd6; regs[3] = 5'd7; regs[4] = 5'd10;
    s = '0;
    r = $urandom_range(0, 99);
    if (r < 35) s.op = ZICFI_LPAD;
    else if (r < 55) s.op = JALR;
    else if (r < 75) s.op = ADD;
    else if (r < 85) s.op = STORE;
    else if (r < 92) s.op = BRANCH;
    else s.op = LOAD;
    s.rs1 = regs[$urandom_range(0, 4)];
    s.rd = ($urandom_range(0, 2) == 0) ? 5'd7 : regs[$urandom_range(0, 4)];
    s.result = labels[$urandom_range(0, 3)];
    s.pc = {$urandom_range(0, 255), ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00};
    s.valid = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 19) == 0) s.ex = '{cause: 32'd5, tval: 32'd0, valid: 1'b1};
    return s;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    #12;
    chk("reset elp", elp_o, NO_LPAD_EXPECTED);
    chk("reset lpl", lpl_o, 0);
    chk("reset pelp", pelp_o, NO_LPAD_EXPECTED);
    chk("reset viol", viol_o, 0);
    chk("reset viol_cnt", viol_cnt_o, 0);
    @(posedge clk); #2; rst_ni = 1'b1;
    step();

    // JALR x10 and LPAD label 0 in the same cycle
    cin[0] = mk(JALR, 5'd10, 5'd1, 32'h0, 32'h100);
    cin[1] = mk(ZICFI_LPAD, 5'd0, 5'd0, 32'h0, 32'h400); ack = 2'b11;
    #1 chk("same-cycle lpad ex", cout[1].ex.valid, 0);
    step();
    chk("same-cycle elp", elp_o, NO_LPAD_EXPECTED);

    // Violation on port0, port1 untouched
    cin[0] = mk(JALR, 5'd10, 5'd0, 32'h0, 32'h100); ack = 2'b01;
    step();
    chk("jalr x10 elp", elp_o, LPAD_EXPECTED);
    cin[0] = mk(ADDI, 5'd2, 5'd3, 32'h7, 32'h200);
    cin[1] = mk(ADD, 5'd2, 5'd4, 32'h9, 32'h204); ack = 2'b11;
    #1 chk("viol cause", cout[0].ex.cause, 32'd18);
    chk("viol tval", cout[0].ex.tval, 32'd2);
    chk("viol port1 unchanged", cout[1], mk(ADD, 5'd2, 5'd4, 32'h9, 32'h204));
    step();
    chk("viol pulse", viol_o, 1);
    chk("viol elp cleared", elp_o, NO_LPAD_EXPECTED);
    step();
    chk("viol pulse ends", viol_o, 0);

    // Label match / mismatch
    cin[0] = mk(ADD, 5'd2, 5'd7, 32'h12345, 32'h300); ack = 2'b01;
    step();
    chk("x7 label", lpl_o, 20'h12345);
    cin[0] = mk(JALR, 5'd6, 5'd0, 32'h0, 32'h304); ack = 2'b01;
    step();
    cin[0] = mk(ZICFI_LPAD, 5'd0, 5'd0, 32'h12345, 32'h800); ack = 2'b01;
    #1 chk("label match", cout[0].ex.valid, 0);
    step();
    cin[0] = mk(JALR, 5'd6, 5'd0, 32'h0, 32'h308); ack = 2'b01;
    step();
    cin[0] = mk(ZICFI_LPAD, 5'd0, 5'd0, 32'h1, 32'h900); ack = 2'b01;
    #1 chk("label mismatch", cout[0].ex.valid, 1);
    step();
    chk("label mismatch pulse", viol_o, 1);

    // Trap saves ELP, xRET restores it
    cin[0] = mk(JALR, 5'd10, 5'd0, 32'h0, 32'h100); ack = 2'b01;
    step();
    trap = 1;
    step();
    chk("trap pelp", pelp_o, LPAD_EXPECTED);
    chk("trap elp", elp_o, NO_LPAD_EXPECTED);
    eret = 1;
    step();
    chk("eret elp", elp_o, LPAD_EXPECTED);
    chk("eret pelp", pelp_o, NO_LPAD_EXPECTED);
    cin[0] = mk(ZICFI_LPAD, 5'd0, 5'd0, 32'h0, 32'ha00); ack = 2'b01;
    step();

    // Exempt JALR sources and unacked JALR
    for (int k = 0; k < 3; k++) begin
      cin[0] = mk(JALR, (k == 0) ? 5'd1 : (k == 1) ? 5'd5 : 5'd7, 5'd0, 32'h0, 32'h100);
      ack = 2'b01;
      step();
      chk($sformatf("exempt jalr %0d", k), elp_o, NO_LPAD_EXPECTED);
    end
    cin[0] = mk(JALR, 5'd10, 5'd0, 32'h0, 32'h100); ack = 2'b00;
    step();
    chk("unacked jalr", elp_o, NO_LPAD_EXPECTED);

    // Two more violations: four in total
    violate();
    violate();
    chk("viol count", viol_cnt_o, CNT_MAX);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      int k;
      for (int p = 0; p < NP; p++) cin[p] = rnd_entry();
      k = $urandom_range(0, NP);
      for (int p = 0; p < NP; p++) ack[p] = (p < k);
      flush = ($urandom_range(0, 19) == 0);
      trap  = ($urandom_range(0, 19) == 0);
      eret  = ($urandom_range(0, 19) == 0);
      lpe   = ($urandom_range(0, 9) != 0);
      @(posedge clk); #2;
    end
    idle();

    // Reset in the middle of a commit
    cin[0] = mk(ADD, 5'd2, 5'd7, 32'h5, 32'h300); ack = 2'b01;
    step();
    cin[0] = mk(JALR, 5'd10, 5'd0, 32'h0, 32'h100); ack = 2'b01;
    step();
    cin[0] = mk(ADD, 5'd2, 5'd7, 32'h1, 32'h300); ack = 2'b01;
    #1 rst_ni = 1'b0;
    #1 chk("midreset elp", elp_o, NO_LPAD_EXPECTED);
    chk("midreset lpl", lpl_o, 0);
    chk("midreset viol_cnt", viol_cnt_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    chk("post-reset elp", elp_o, NO_LPAD_EXPECTED);
    chk("post-reset lpl", lpl_o, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
